alu_ctrl: RTL and testbench
===========================

// Module: alu_ctrl
// PURPOSE
//  Multi-cycle issue/control sequencer that drives the 8-bit ALU. Accepts 9-bit
//  register-register instructions over a valid/ready handshake, reads operands
//  from an internal 8x8 register file and presents a/b/alu_op to the ALU.
//  It then captures result/zero and writes the result back. Sits between the
//  fetch stage and the ALU.
// PARAMETERS
//  NREGS   8  register-file depth; must be 8 to match 3-bit register fields
//  DW      8  datapath width; must be 8 to match the ALU
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     asynchronous active-low reset
//  instr_valid  in   1     instr holds a valid instruction
//  instr_ready  out  1     sequencer can accept; transfer = valid && ready
//  instr        in   9     [8:6] op (ALU encoding), [5:3] rd, [2:0] rs
//  host_we      in   1     host register write (RF preload)
//  host_addr    in   3     host write address
//  host_data    in   8     host write data
//  alu_a        out  8     operand a = RF[rd], registered
//  alu_b        out  8     operand b = RF[rs], registered
//  alu_op       out  3     operation code, registered
//  alu_result   in   8     ALU result (combinational from alu_a/b/op)
//  alu_zero     in   1     ALU zero flag
//  zero_flag    out  1     zero flag latched from the last non-NOP instruction
//  done         out  1     one-cycle pulse in WB when the instruction retires
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all RF entries=0. alu_a, alu_b and
//   alu_op = 0. zero_flag=0, done=0. instr_ready=0 while rst_n=0.
//  FSM: IDLE -> READ -> EXEC -> WB -> IDLE; no other transitions.
//   IDLE: instr_ready = !host_we. On transfer, latch instr and go to READ.
//         Host write is accepted only in IDLE; RF[host_addr] <= host_data.
//         host_we blocks acceptance in the same cycle.
//   READ: alu_a <= RF[rd], alu_b <= RF[rs], alu_op <= op.
//   EXEC: ALU evaluates; latch alu_result/alu_zero into internal regs.
//   WB:   if op != 3'b111, RF[rd] <= result and zero_flag <= zero.
//         op 3'b111 is a NOP: no RF write, zero_flag held. done=1 for this
//         cycle only.
//  Latency: transfer in cycle N -> done in N+3. The earliest next accept is in
//   N+4, so throughput is 1 instruction per 4 cycles.
//  rd == rs is legal; both operands read the same pre-write value.
//  host_we outside IDLE is ignored; no write occurs.
//  instr_valid/instr change while busy: ignored; instr_ready=0 outside IDLE.
//  Reset mid-operation aborts the instruction: no RF write, no done.
//  Arithmetic is entirely in the ALU. The sequencer stores the 8-bit result
//   unmodified (carry dropped, shifts by >=8 yield 0 per ALU).
// CONFIGURATION
//  `ALU_CTRL_DBG_EN defined: adds ports dbg_addr in 3 and dbg_data out 8.
//   dbg_data = RF[dbg_addr] is a combinational read in any state, showing the
//   written value from the cycle after a WB/host write.
//  Not defined: these ports and the read mux are absent; behaviour is otherwise
//   identical.
// STRUCTURE
//  Package alu_ctrl_pkg: typedef enum logic[1:0] {IDLE,READ,EXEC,WB} ctrl_state_t;
//   ALU op constants OP_AND=0, OP_ADD=1, OP_XOR=2, OP_SLT=3, OP_SLL=4,
//   OP_SRL=5, OP_SNE=6, OP_NOP=7. Instruction field position localparams.
//  Sub-module reg_file_8x8: 2 async read ports, 1 sync write port, async reset
//   to 0. WB and host writes are muxed onto its write port; they are never
//   simultaneous by construction.
// TESTING
//  1 Reset: hold rst_n=0 mid-EXEC -> RF all 0, alu_a/b/op=0, done=0,
//    instr_ready=0; after release instr_ready=1.
//  2 ADD: host RF[1]=8'h0F, RF[2]=8'hF2; issue op=001 rd=1 rs=2 ->
//    done at +3, RF[1]=8'h01 (carry dropped), zero_flag=0.
//  3 XOR self: RF[3]=8'hA5; issue op=010 rd=3 rs=3 -> RF[3]=0, zero_flag=1.
//  4 NOP: zero_flag=1, issue op=111 rd=4 -> done pulses; RF[4] and
//    zero_flag unchanged.
//  5 Handshake: instr_valid held high for 10 cycles -> exactly 3 accepts
//    (cycles 0, 4, 8). host_we=1 in IDLE forces instr_ready=0.
//  6 Shift/compare: RF[5]=8'h81, RF[6]=8'd1; op=101 rd=5 rs=6 -> 8'h40.
//    Then op=011 with RF[5]=8'h40, RF[6]=8'h41 -> RF[5]=8'h01.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the alu_ctrl issue/control sequencer.
// Optional debug read port is enabled by defining ALU_CTRL_DBG_EN.
package alu_ctrl_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned OPW   = 3;
  localparam int unsigned IW    = 9;

  // Instruction field positions: [8:6] op, [5:3] rd, [2:0] rs
  localparam int unsigned OP_MSB = 8;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RD_MSB = 5;
  localparam int unsigned RD_LSB = 3;
  localparam int unsigned RS_MSB = 2;
  localparam int unsigned RS_LSB = 0;

  localparam logic [OPW-1:0] OP_AND = 3'd0;
  localparam logic [OPW-1:0] OP_ADD = 3'd1;
  localparam logic [OPW-1:0] OP_XOR = 3'd2;
  localparam logic [OPW-1:0] OP_SLT = 3'd3;
  localparam logic [OPW-1:0] OP_SLL = 3'd4;
  localparam logic [OPW-1:0] OP_SRL = 3'd5;
  localparam logic [OPW-1:0] OP_SNE = 3'd6;
  localparam logic [OPW-1:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} ctrl_state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  rs;
  } instr_t;

  function automatic instr_t decode_instr(input logic [IW-1:0] raw);
    instr_t d;
    d.op = raw[OP_MSB:OP_LSB];
    d.rd = raw[RD_MSB:RD_LSB];
    d.rs = raw[RS_MSB:RS_LSB];
    return d;
  endfunction

  // NOP is the only op that leaves the register file and zero flag untouched
  function automatic logic op_writes_back(input logic [OPW-1:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/alu_ctrl_reg_file.sv
// reg_file_8x8: two async read ports, one sync write port, async clear.
// With ALU_CTRL_DBG_EN defined a third async read port is added for debug.
module reg_file_8x8
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
`ifdef ALU_CTRL_DBG_EN
  ,
  input  logic [AW-1:0] raddr_d_i,
  output logic [DW-1:0] rdata_d_o
`endif
);

  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

`ifdef ALU_CTRL_DBG_EN
  assign rdata_d_o = mem_q[raddr_d_i];
`endif

endmodule

// File: rtl/alu_ctrl.sv
// Four-phase issue sequencer (IDLE/READ/EXEC/WB) driving an external 8-bit ALU.
// Defining ALU_CTRL_DBG_EN adds dbg_addr/dbg_data for combinational RF inspection.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [IW-1:0]  instr,
  input  logic           host_we,
  input  logic [AW-1:0]  host_addr,
  input  logic [DW-1:0]  host_data,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_zero,
  output logic           zero_flag,
  output logic           done
`ifdef ALU_CTRL_DBG_EN
  ,
  input  logic [AW-1:0]  dbg_addr,
  output logic [DW-1:0]  dbg_data
`endif
);

  ctrl_state_t    state_q, state_d;
  instr_t         instr_q, instr_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  res_q, res_d;
  logic           rzero_q, rzero_d;
  logic           zflag_q, zflag_d;
  logic           done_q, done_d;

  logic           rf_we_c;
  logic [AW-1:0]  rf_waddr_c;
  logic [DW-1:0]  rf_wdata_c;
  logic [DW-1:0]  rdata_a_c;
  logic [DW-1:0]  rdata_b_c;

  // Host writes (IDLE only) and WB writes share the single RF write port
  reg_file_8x8 u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we_c),
    .waddr_i   (rf_waddr_c),
    .wdata_i   (rf_wdata_c),
    .raddr_a_i (instr_q.rd),
    .rdata_a_o (rdata_a_c),
    .raddr_b_i (instr_q.rs),
    .rdata_b_o (rdata_b_c)
`ifdef ALU_CTRL_DBG_EN
    ,
    .raddr_d_i (dbg_addr),
    .rdata_d_o (dbg_data)
`endif
  );

  // Ready is gated by reset so nothing is offered while the block is held
  assign instr_ready = rst_n && (state_q == IDLE) && !host_we;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    rzero_d    = rzero_q;
    zflag_d    = zflag_q;
    rf_we_c    = 1'b0;
    rf_waddr_c = host_addr;
    rf_wdata_c = host_data;

    case (state_q)
      IDLE: begin
        if (host_we) begin
          rf_we_c = 1'b1;
        end else if (instr_valid) begin
          instr_d = decode_instr(instr);
          state_d = READ;
        end
      end
      READ: begin
        a_d     = rdata_a_c;
        b_d     = rdata_b_c;
        op_d    = instr_q.op;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_result;
        rzero_d = alu_zero;
        state_d = WB;
      end
      WB: begin
        if (op_writes_back(instr_q.op)) begin
          rf_we_c    = 1'b1;
          rf_waddr_c = instr_q.rd;
          rf_wdata_c = res_q;
          zflag_d    = rzero_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // done is registered so it is high exactly while the FSM sits in WB
    done_d = (state_d == WB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      rzero_q <= 1'b0;
      zflag_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      rzero_q <= rzero_d;
      zflag_q <= zflag_d;
      done_q  <= done_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign zero_flag = zflag_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: behavioural ALU, RF/zero-flag model and
// an in-order scoreboard of issued instructions checked when done pulses.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr;
  logic       host_we;
  logic [2:0] host_addr;
  logic [7:0] host_data;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       zero_flag;
  logic       done;
`ifdef ALU_CTRL_DBG_EN
  logic [2:0] dbg_addr = 3'd0;
  logic [7:0] dbg_data;
`endif

  alu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .zero_flag   (zero_flag),
    .done        (done)
`ifdef ALU_CTRL_DBG_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a + b;
      3'd2:    return a ^ b;
      3'd3:    return (a < b) ? 8'd1 : 8'd0;
      3'd4:    return (b >= 8'd8) ? 8'd0 : (a << b[2:0]);
      3'd5:    return (b >= 8'd8) ? 8'd0 : (a >> b[2:0]);
      3'd6:    return (a != b) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_op, alu_a, alu_b);
    alu_zero   = (alu_result == 8'd0);
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op, rd, rs;
    logic [7:0] a, b, res;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         xfer_cyc[$];
  int         xfer_cnt = 0;
  logic [7:0] rf_m [8];
  logic       zf_m;

  // Monitor: samples on the falling edge; inputs change just after rising edges
  always @(negedge clk) begin
    logic exp_ready, exp_done;
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      for (int i = 0; i < 8; i++) rf_m[i] = 8'd0;
      zf_m = 1'b0;
      chk("reset_ready", 32'(instr_ready), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
    end else begin
      exp_ready = (sb_q.size() == 0) && !host_we;
      exp_done  = (sb_q.size() != 0) && (cyc == sb_q[0].cyc + 3);
      chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
      chk("zero_flag", 32'(zero_flag), 32'(zf_m));
      chk("done", 32'(done), 32'(exp_done));
      if (host_we && sb_q.size() == 0) rf_m[host_addr] = host_data;
      if (exp_done) begin
        e = sb_q.pop_front();
        chk("alu_a", 32'(alu_a), 32'(e.a));
        chk("alu_b", 32'(alu_b), 32'(e.b));
        chk("alu_op", 32'(alu_op), 32'(e.op));
        if (e.op != 3'd7) begin
          rf_m[e.rd] = e.res;
          zf_m       = e.z;
        end
      end
      if (instr_valid && exp_ready) begin
        e.op  = instr[8:6];
        e.rd  = instr[5:3];
        e.rs  = instr[2:0];
        e.a   = rf_m[e.rd];
        e.b   = rf_m[e.rs];
        e.res = alu_f(e.op, e.a, e.b);
        e.z   = (e.res == 8'd0);
        e.cyc = cyc;
        sb_q.push_back(e);
        xfer_cyc.push_back(cyc);
        xfer_cnt++;
      end
    end
  end

  task automatic host_wr(input logic [2:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    host_we = 1'b1; host_addr = addr; host_data = data;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
    int start;
    start = xfer_cnt;
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr       = {op, rd, rs};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (xfer_cnt != start) break;
    end
    #1;
    instr_valid = 1'b0;
    chk("issue_accept", 32'(xfer_cnt != start), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("wait_idle", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic read_rf(input logic [2:0] ra, input logic [2:0] rb, output logic [7:0] va, output logic [7:0] vb);
    issue(3'd7, ra, rb);
    wait_idle();
    va = alu_a;
    vb = alu_b;
  endtask

  typedef struct {
    string      name;
    logic [2:0] op, rd, rs;
    logic [7:0] rd_val, rs_val;
    logic [7:0] exp_res;
    logic       exp_z;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] va, vb;
    int base, n;

    vecs[0] = '{"add_carry",  3'd1, 3'd1, 3'd2, 8'h0F, 8'hF2, 8'h01, 1'b0};
    vecs[1] = '{"xor_self",   3'd2, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'h00, 1'b1};
    vecs[2] = '{"srl_1",      3'd5, 3'd5, 3'd6, 8'h81, 8'h01, 8'h40, 1'b0};
    vecs[3] = '{"slt_true",   3'd3, 3'd5, 3'd6, 8'h40, 8'h41, 8'h01, 1'b0};
    vecs[4] = '{"and_zero",   3'd0, 3'd0, 3'd7, 8'hF0, 8'h0F, 8'h00, 1'b1};
    vecs[5] = '{"sll_1",      3'd4, 3'd2, 3'd4, 8'h81, 8'h01, 8'h02, 1'b0};
    vecs[6] = '{"sll_8",      3'd4, 3'd2, 3'd4, 8'hFF, 8'h08, 8'h00, 1'b1};
    vecs[7] = '{"sne_equal",  3'd6, 3'd1, 3'd2, 8'h33, 8'h33, 8'h00, 1'b1};
    vecs[8] = '{"add_wrap",   3'd1, 3'd6, 3'd7, 8'hFF, 8'h01, 8'h00, 1'b1};

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    host_we = 1'b0; host_addr = '0; host_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("por_alu_a", 32'(alu_a), 32'd0);
    chk("por_alu_b", 32'(alu_b), 32'd0);
    chk("por_alu_op", 32'(alu_op), 32'd0);
    chk("por_zero_flag", 32'(zero_flag), 32'd0);
    chk("por_ready", 32'(instr_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("por_ready_release", 32'(instr_ready), 32'd1);

    // Table-driven vectors: preload, execute, check flag and readback
    foreach (vecs[k]) begin
      host_wr(vecs[k].rd, vecs[k].rd_val);
      if (vecs[k].rs != vecs[k].rd) host_wr(vecs[k].rs, vecs[k].rs_val);
      issue(vecs[k].op, vecs[k].rd, vecs[k].rs);
      wait_idle();
      chk({"zf_", vecs[k].name}, 32'(zero_flag), 32'(vecs[k].exp_z));
      read_rf(vecs[k].rd, vecs[k].rs, va, vb);
      chk({"res_", vecs[k].name}, 32'(va), 32'(vecs[k].exp_res));
    end

    // NOP leaves RF and a set zero flag untouched
    host_wr(3'd3, 8'hA5);
    issue(3'd2, 3'd3, 3'd3);
    wait_idle();
    chk("nop_pre_zf", 32'(zero_flag), 32'd1);
    host_wr(3'd4, 8'h5A);
    issue(3'd7, 3'd4, 3'd0);
    wait_idle();
    chk("nop_zf_held", 32'(zero_flag), 32'd1);
    read_rf(3'd4, 3'd4, va, vb);
    chk("nop_rf4", 32'(va), 32'h5A);

    // Valid held for 10 cycles: accepts at +0, +4, +8 only
    @(posedge clk); #1;
    base = cyc;
    xfer_cyc.delete();
    instr_valid = 1'b1;
    instr = {3'd7, 3'd0, 3'd1};
    repeat (10) @(posedge clk);
    #1;
    instr_valid = 1'b0;
    wait_idle();
    n = xfer_cyc.size();
    chk("hs_accepts", 32'(n), 32'd3);
    if (n == 3) begin
      chk("hs_accept0", 32'(xfer_cyc[0] - base), 32'd0);
      chk("hs_accept1", 32'(xfer_cyc[1] - base), 32'd4);
      chk("hs_accept2", 32'(xfer_cyc[2] - base), 32'd8);
    end

    // host_we in IDLE blocks acceptance in the same cycle
    @(posedge clk); #1;
    n = xfer_cnt;
    host_we = 1'b1; host_addr = 3'd6; host_data = 8'h66;
    instr_valid = 1'b1; instr = {3'd1, 3'd0, 3'd0};
    #1;
    chk("hostwe_blocks_ready", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    host_we = 1'b0; instr_valid = 1'b0;
    chk("hostwe_no_accept", 32'(xfer_cnt - n), 32'd0);

    // host_we while busy is ignored
    host_wr(3'd1, 8'h10);
    host_wr(3'd2, 8'h20);
    issue(3'd1, 3'd1, 3'd2);
    host_we = 1'b1; host_addr = 3'd6; host_data = 8'hEE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    host_we = 1'b0;
    wait_idle();
    read_rf(3'd1, 3'd6, va, vb);
    chk("busy_add_rf1", 32'(va), 32'h30);
    chk("busy_hostwe_ignored", 32'(vb), 32'h66);

    // Reset asserted mid-EXEC aborts the instruction and clears everything
    issue(3'd2, 3'd1, 3'd1);
    wait_idle();
    chk("pre_reset_zf", 32'(zero_flag), 32'd1);
    issue(3'd1, 3'd6, 3'd6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready", 32'(instr_ready), 32'd0);
    chk("mid_rst_zf", 32'(zero_flag), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    for (int r = 0; r < 4; r++) begin
      read_rf(3'(r), 3'(r + 4), va, vb);
      chk("post_rst_rf_lo", 32'(va), 32'd0);
      chk("post_rst_rf_hi", 32'(vb), 32'd0);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
